// File: rtl/bus_pkg.sv
// Shared types for the 8085 bus-cycle sequencer: cycle kinds, T-states,
// the latched request, and per-type decode helpers.
package bus_pkg;

  typedef enum logic [2:0] {
    MC_OF   = 3'd0,
    MC_MR   = 3'd1,
    MC_MW   = 3'd2,
    MC_IOR  = 3'd3,
    MC_IOW  = 3'd4,
    MC_INTA = 3'd5
  } mcycle_t;

  typedef enum logic [2:0] {
    TS_IDLE  = 3'd0,
    TS_T1    = 3'd1,
    TS_T2    = 3'd2,
    TS_TWAIT = 3'd3,
    TS_T3    = 3'd4,
    TS_T4    = 3'd5,
    TS_THOLD = 3'd6
  } tstate_t;

  typedef struct packed {
    mcycle_t     typ;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } bus_req_t;

  // {IOMn, S1, S0}
  function automatic logic [2:0] bus_status(mcycle_t t);
    case (t)
      MC_OF:   return 3'b011;
      MC_MR:   return 3'b010;
      MC_MW:   return 3'b001;
      MC_IOR:  return 3'b110;
      MC_IOW:  return 3'b101;
      MC_INTA: return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic is_write(mcycle_t t);
    return (t == MC_MW) || (t == MC_IOW);
  endfunction

  function automatic logic is_four_state(mcycle_t t);
    return (t == MC_OF) || (t == MC_INTA);
  endfunction

endpackage

// File: rtl/bus_cycle_sequencer.sv
// 8085 machine-cycle sequencer: steps one latched request through T1..T4,
// stretches on READY, and yields the bus on HOLD at cycle boundaries.
module bus_cycle_sequencer
  import bus_pkg::*;
(
  input  logic        phi1,
  input  logic        resetn_in,
  input  logic        req,
  input  logic [2:0]  req_type,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        ack,
  output logic        done,
  output logic [7:0]  rdata,
  output logic        rdata_valid,
  input  logic [7:0]  ad_in,
  output logic [7:0]  ad_out,
  output logic        ad_oe,
  output logic [7:0]  haddress,
  output logic        bus_oe,
  output logic        ALE,
  output logic        RDn,
  output logic        WRn,
  output logic        INTAn,
  output logic        IOMn,
  output logic        S0,
  output logic        S1,
  input  logic        READY,
  input  logic        HOLD,
  output logic        HLDA,
  output logic [2:0]  tstate
);

  tstate_t  state, state_nxt;
  bus_req_t cur;

  logic four, wr, type_ok, at_dp, in_cyc, strobe;

  assign four    = is_four_state(cur.typ);
  assign wr      = is_write(cur.typ);
  assign type_ok = (req_type <= 3'd5);
  assign at_dp   = (state == TS_IDLE) || (state == TS_T4) || (state == TS_T3 && !four);
  assign in_cyc  = (state == TS_T1) || (state == TS_T2) || (state == TS_TWAIT) ||
                   (state == TS_T3) || (state == TS_T4);
  assign strobe  = (state == TS_T2) || (state == TS_TWAIT) || (state == TS_T3);
  assign tstate  = state;

  // Next state and the combinational ack; the decision point has priority
  // over the in-cycle sequencing so T3/T4 fall straight into it.
  always_comb begin
    state_nxt = state;
    ack       = 1'b0;
    if (at_dp) begin
      if (HOLD) begin
        state_nxt = TS_THOLD;
      end else if (req && type_ok) begin
        state_nxt = TS_T1;
        ack       = 1'b1;
      end else begin
        state_nxt = TS_IDLE;
      end
    end else begin
      case (state)
        TS_T1:    state_nxt = TS_T2;
        TS_T2,
        TS_TWAIT: state_nxt = READY ? TS_T3 : TS_TWAIT;
        TS_T3:    state_nxt = TS_T4;
        TS_THOLD: state_nxt = HOLD ? TS_THOLD : TS_IDLE;
        default:  state_nxt = TS_IDLE;
      endcase
    end
  end

  always_ff @(posedge phi1 or negedge resetn_in) begin
    if (!resetn_in) begin
      state       <= TS_IDLE;
      cur         <= '{typ: MC_OF, addr: 16'h0000, wdata: 8'h00};
      rdata       <= 8'h00;
      rdata_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      rdata_valid <= 1'b0;
      if (ack)
        cur <= '{typ: mcycle_t'(req_type), addr: req_addr, wdata: req_wdata};
      // T3 is always left on the next edge, so this is the leaving-T3 capture
      if (state == TS_T3 && !wr) begin
        rdata       <= ad_in;
        rdata_valid <= 1'b1;
      end
    end
  end

  always_comb begin
    ALE            = 1'b0;
    RDn            = 1'b1;
    WRn            = 1'b1;
    INTAn          = 1'b1;
    {IOMn, S1, S0} = 3'b000;
    ad_oe          = 1'b0;
    ad_out         = 8'h00;
    haddress       = 8'h00;
    bus_oe         = (state != TS_THOLD);
    HLDA           = (state == TS_THOLD);
    done           = (state == TS_T4) || (state == TS_T3 && !four);
    if (in_cyc) begin
      {IOMn, S1, S0} = bus_status(cur.typ);
      haddress       = cur.addr[15:8];
    end
    if (state == TS_T1) begin
      ALE    = 1'b1;
      ad_oe  = 1'b1;
      ad_out = cur.addr[7:0];
    end
    if (strobe) begin
      if (wr) begin
        WRn    = 1'b0;
        ad_oe  = 1'b1;
        ad_out = cur.wdata;
      end else if (cur.typ == MC_INTA) begin
        INTAn = 1'b0;
      end else begin
        RDn = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// Directed, table-driven bench for bus_cycle_sequencer plus a hand-written
// mid-cycle reset sequence.
module tb_bus_cycle_sequencer;

  logic        phi1 = 1'b0;
  logic        resetn_in;
  logic        req;
  logic [2:0]  req_type;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        ack, done, rdata_valid, ad_oe, bus_oe;
  logic [7:0]  rdata, ad_out, haddress, ad_in;
  logic        ALE, RDn, WRn, INTAn, IOMn, S0, S1;
  logic        READY, HOLD, HLDA;
  logic [2:0]  tstate;

  int checks = 0;
  int errors = 0;

  bus_cycle_sequencer dut (
    .phi1(phi1), .resetn_in(resetn_in), .req(req), .req_type(req_type),
    .req_addr(req_addr), .req_wdata(req_wdata), .ack(ack), .done(done),
    .rdata(rdata), .rdata_valid(rdata_valid), .ad_in(ad_in), .ad_out(ad_out),
    .ad_oe(ad_oe), .haddress(haddress), .bus_oe(bus_oe), .ALE(ALE), .RDn(RDn),
    .WRn(WRn), .INTAn(INTAn), .IOMn(IOMn), .S0(S0), .S1(S1), .READY(READY),
    .HOLD(HOLD), .HLDA(HLDA), .tstate(tstate)
  );

  always #5 phi1 = ~phi1;

  // ctl = {ack,done}_{ALE}_{RDn,WRn,INTAn}_{IOMn,S1,S0}_{ad_oe,bus_oe,HLDA}_{rdata_valid}
  typedef struct {
    logic        rq;
    logic [2:0]  typ;
    logic [15:0] addr;
    logic [7:0]  wd, adin;
    logic        rdy, hold;
    logic [2:0]  ts;
    logic [12:0] ctl;
    logic [7:0]  ado, ha, rd;
  } vec_t;

  vec_t tbl[$];
  localparam logic [12:0] IDL = 13'b00_0_111_000_010_0;

  task automatic add(input logic rq, input logic [2:0] typ, input logic [15:0] addr,
                     input logic [7:0] wd, input logic [7:0] adin, input logic rdy,
                     input logic hold, input logic [2:0] ts, input logic [12:0] ctl,
                     input logic [7:0] ado, input logic [7:0] ha, input logic [7:0] rd);
    vec_t v;
    v = '{rq: rq, typ: typ, addr: addr, wd: wd, adin: adin, rdy: rdy, hold: hold,
          ts: ts, ctl: ctl, ado: ado, ha: ha, rd: rd};
    tbl.push_back(v);
  endtask

  function automatic logic [12:0] ctl_now();
    return {ack, done, ALE, RDn, WRn, INTAn, IOMn, S1, S0, ad_oe, bus_oe, HLDA, rdata_valid};
  endfunction

  task automatic check(input string name, input logic [2:0] ts, input logic [12:0] ctl,
                       input logic [7:0] ado, input logic [7:0] ha, input logic [7:0] rd);
    checks++;
    if (tstate !== ts || ctl_now() !== ctl || ad_out !== ado || haddress !== ha || rdata !== rd) begin
      errors++;
      $display("FAIL %s: got ts=%0d ctl=%b ad_out=%h ha=%h rdata=%h, want ts=%0d ctl=%b ad_out=%h ha=%h rdata=%h",
               name, tstate, ctl_now(), ad_out, haddress, rdata, ts, ctl, ado, ha, rd);
    end
  endtask

  initial begin
    resetn_in = 1'b0; req = 1'b0; req_type = 3'd0; req_addr = 16'h0; req_wdata = 8'h0;
    ad_in = 8'h0; READY = 1'b1; HOLD = 1'b0;

    // MR 2050 with READY=1
    add(0,0,16'h0000,8'h00,8'h00,1,0, 0, IDL,                  8'h00,8'h00,8'h00);
    add(1,1,16'h2050,8'h00,8'h00,1,0, 0, 13'b10_0_111_000_010_0,8'h00,8'h00,8'h00);
    add(0,0,16'h0000,8'h00,8'h00,1,0, 1, 13'b00_1_111_010_110_0,8'h50,8'h20,8'h00);
    add(0,0,16'h0000,8'h00,8'h00,1,0, 2, 13'b00_0_011_010_010_0,8'h00,8'h20,8'h00);
    add(0,0,16'h0000,8'h00,8'hA5,1,0, 4, 13'b01_0_011_010_010_0,8'h00,8'h20,8'h00);
    add(0,0,16'h0000,8'h00,8'h00,1,0, 0, 13'b00_0_111_000_010_1,8'h00,8'h00,8'hA5);
    // OF 1234 with three wait states
    add(1,0,16'h1234,8'h00,8'h00,1,0, 0, 13'b10_0_111_000_010_0,8'h00,8'h00,8'hA5);
    add(0,0,16'h0000,8'h00,8'h00,0,0, 1, 13'b00_1_111_011_110_0,8'h34,8'h12,8'hA5);
    add(0,0,16'h0000,8'h00,8'h00,0,0, 2, 13'b00_0_011_011_010_0,8'h00,8'h12,8'hA5);
    add(0,0,16'h0000,8'h00,8'h00,0,0, 3, 13'b00_0_011_011_010_0,8'h00,8'h12,8'hA5);
    add(0,0,16'h0000,8'h00,8'h00,0,0, 3, 13'b00_0_011_011_010_0,8'h00,8'h12,8'hA5);
    add(0,0,16'h0000,8'h00,8'h00,1,0, 3, 13'b00_0_011_011_010_0,8'h00,8'h12,8'hA5);
    add(0,0,16'h0000,8'h00,8'hC3,1,0, 4, 13'b00_0_011_011_010_0,8'h00,8'h12,8'hA5);
    // T4 is a DP: IOW 003F accepted back-to-back, then MR back-to-back
    add(1,4,16'h003F,8'h7E,8'h00,1,0, 5, 13'b11_0_111_011_010_1,8'h00,8'h12,8'hC3);
    add(0,0,16'h0000,8'h00,8'h00,1,0, 1, 13'b00_1_111_101_110_0,8'h3F,8'h00,8'hC3);
    add(0,0,16'h0000,8'h00,8'h00,1,0, 2, 13'b00_0_101_101_110_0,8'h7E,8'h00,8'hC3);
    add(1,1,16'h2050,8'h00,8'h00,1,0, 4, 13'b11_0_101_101_110_0,8'h7E,8'h00,8'hC3);
    add(0,0,16'h0000,8'h00,8'h00,1,0, 1, 13'b00_1_111_010_110_0,8'h50,8'h20,8'hC3);
    add(0,0,16'h0000,8'h00,8'h00,1,0, 2, 13'b00_0_011_010_010_0,8'h00,8'h20,8'hC3);
    add(0,0,16'h0000,8'h00,8'h5A,1,0, 4, 13'b01_0_011_010_010_0,8'h00,8'h20,8'hC3);
    add(0,0,16'h0000,8'h00,8'h00,1,0, 0, 13'b00_0_111_000_010_1,8'h00,8'h00,8'h5A);
    // unknown types ignored
    add(1,7,16'hFFFF,8'h00,8'h00,1,0, 0, IDL,                  8'h00,8'h00,8'h5A);
    add(1,6,16'hFFFF,8'h00,8'h00,1,0, 0, IDL,                  8'h00,8'h00,8'h5A);
    add(0,0,16'h0000,8'h00,8'h00,1,0, 0, IDL,                  8'h00,8'h00,8'h5A);
    // MW 4000 with HOLD raised in T2; MR pending through hold
    add(1,2,16'h4000,8'h11,8'h00,1,0, 0, 13'b10_0_111_000_010_0,8'h00,8'h00,8'h5A);
    add(0,0,16'h0000,8'h00,8'h00,1,0, 1, 13'b00_1_111_001_110_0,8'h00,8'h40,8'h5A);
    add(0,0,16'h0000,8'h00,8'h00,1,1, 2, 13'b00_0_101_001_110_0,8'h11,8'h40,8'h5A);
    add(1,1,16'h2050,8'h00,8'h00,1,1, 4, 13'b01_0_101_001_110_0,8'h11,8'h40,8'h5A);
    add(1,1,16'h2050,8'h00,8'h00,1,1, 6, 13'b00_0_111_000_001_0,8'h00,8'h00,8'h5A);
    add(1,1,16'h2050,8'h00,8'h00,1,0, 6, 13'b00_0_111_000_001_0,8'h00,8'h00,8'h5A);
    add(1,1,16'h2050,8'h00,8'h00,1,0, 0, 13'b10_0_111_000_010_0,8'h00,8'h00,8'h5A);
    add(0,0,16'h0000,8'h00,8'h00,1,0, 1, 13'b00_1_111_010_110_0,8'h50,8'h20,8'h5A);
    add(0,0,16'h0000,8'h00,8'h00,1,0, 2, 13'b00_0_011_010_010_0,8'h00,8'h20,8'h5A);
    add(0,0,16'h0000,8'h00,8'h99,1,0, 4, 13'b01_0_011_010_010_0,8'h00,8'h20,8'h5A);
    add(0,0,16'h0000,8'h00,8'h00,1,0, 0, 13'b00_0_111_000_010_1,8'h00,8'h00,8'h99);
    // INTA: INTAn in place of RDn, four states
    add(1,5,16'h0038,8'h00,8'h00,1,0, 0, 13'b10_0_111_000_010_0,8'h00,8'h00,8'h99);
    add(0,0,16'h0000,8'h00,8'h00,1,0, 1, 13'b00_1_111_111_110_0,8'h38,8'h00,8'h99);
    add(0,0,16'h0000,8'h00,8'h00,1,0, 2, 13'b00_0_110_111_010_0,8'h00,8'h00,8'h99);
    add(0,0,16'h0000,8'h00,8'hE7,1,0, 4, 13'b00_0_110_111_010_0,8'h00,8'h00,8'h99);
    add(0,0,16'h0000,8'h00,8'h00,1,0, 5, 13'b01_0_111_111_010_1,8'h00,8'h00,8'hE7);
    add(0,0,16'h0000,8'h00,8'h00,1,0, 0, IDL,                  8'h00,8'h00,8'hE7);

    // reset values while held in reset
    repeat (2) @(negedge phi1);
    #1 check("reset_state", 3'd0, IDL, 8'h00, 8'h00, 8'h00);
    @(negedge phi1) resetn_in = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge phi1);
      req = tbl[i].rq; req_type = tbl[i].typ; req_addr = tbl[i].addr;
      req_wdata = tbl[i].wd; ad_in = tbl[i].adin; READY = tbl[i].rdy; HOLD = tbl[i].hold;
      #1 check($sformatf("vec%0d", i), tbl[i].ts, tbl[i].ctl, tbl[i].ado, tbl[i].ha, tbl[i].rd);
    end

    // reset asserted during TWAIT of an MR
    @(negedge phi1);
    req = 1'b1; req_type = 3'd1; req_addr = 16'h1111; READY = 1'b0; ad_in = 8'h00;
    @(negedge phi1) req = 1'b0;
    #1 check("rst_seq_t1", 3'd1, 13'b00_1_111_010_110_0, 8'h11, 8'h11, 8'hE7);
    @(negedge phi1);
    @(negedge phi1);
    #1 check("rst_seq_twait", 3'd3, 13'b00_0_011_010_010_0, 8'h00, 8'h11, 8'hE7);
    resetn_in = 1'b0;
    #1 check("rst_immediate", 3'd0, IDL, 8'h00, 8'h00, 8'h00);
    READY = 1'b1;
    @(negedge phi1);
    #1 check("rst_held", 3'd0, IDL, 8'h00, 8'h00, 8'h00);
    resetn_in = 1'b1;
    @(negedge phi1);
    #1 check("rst_release", 3'd0, IDL, 8'h00, 8'h00, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
